// File: rtl/mem_bus_responder.sv
// Memory-side responder for the 13-bit CPU bus. It serves RAM (1800H-1FFFH) from
// internal storage and ROM (0000H-17FFH) through a registered external ROM port.
// It adds wait states per region, a one-cycle ready pulse and error reporting.
module mem_bus_responder #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RAM_AW   = 11,
  parameter int unsigned ROM_WAIT = 2,
  parameter int unsigned RAM_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [12:0]       addr,
  input  logic              rd,
  input  logic              wr,
  input  logic              rom_sel,
  input  logic              ram_sel,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              bus_err,
  output logic [12:0]       rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int unsigned MAX_WAIT = (ROM_WAIT > RAM_WAIT) ? ROM_WAIT : RAM_WAIT;
  localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned RAM_SIZE = 1 << RAM_AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_req_err;
  logic [CNT_W-1:0]    w_cnt_load;

  logic [CNT_W-1:0]    r_cnt;
  logic [12:0]         r_rom_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_wr;
  logic                r_is_rom;
  logic                r_err;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_ready;
  logic                r_bus_err;

  logic [DATA_W-1:0]   r_ram [RAM_SIZE];
  logic [RAM_AW-1:0]   w_ram_idx;

  assign w_ram_idx = r_rom_addr[RAM_AW-1:0];
  assign data_out  = r_data_out;
  assign ready     = r_ready;
  assign bus_err   = r_bus_err;
  assign rom_addr  = r_rom_addr;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, request classification and wait-count selection
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_cnt_load = '0;
    w_req_err  = (rd & wr) | (wr & rom_sel) | (rom_sel == ram_sel);
    case (r_state)
      S_IDLE: begin
        if (rd | wr) begin
          w_accept = 1'b1;
          if (w_req_err) begin
            w_next = S_RESP;
          end else if (rom_sel) begin
            w_cnt_load = CNT_W'(ROM_WAIT - 1);
            w_next     = S_WAIT;
          end else if (RAM_WAIT == 0) begin
            w_next = S_RESP;
          end else begin
            w_cnt_load = CNT_W'(RAM_WAIT - 1);
            w_next     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_HOLD;
      end
      S_HOLD: begin
        if (!rd && !wr) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request latch, wait counter, read-data capture and response pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_rom_addr <= '0;
      r_wdata    <= '0;
      r_is_wr    <= 1'b0;
      r_is_rom   <= 1'b0;
      r_err      <= 1'b0;
      r_data_out <= '0;
      r_ready    <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_ready   <= (r_state == S_RESP);
      r_bus_err <= (r_state == S_RESP) && r_err;
      if (w_accept) begin
        r_rom_addr <= addr;
        r_wdata    <= data_in;
        r_is_wr    <= wr;
        r_is_rom   <= rom_sel;
        r_err      <= w_req_err;
        r_cnt      <= w_cnt_load;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // ROM data is valid one cycle after rom_addr; capture it on the way into RESP
      if (r_state == S_WAIT && r_cnt == '0 && r_is_rom && !r_err) begin
        r_data_out <= rom_data;
      end
      if (r_state == S_RESP && !r_err && !r_is_wr && !r_is_rom) begin
        r_data_out <= r_ram[w_ram_idx];
      end
    end
  end

  // RAM write commits on the edge leaving RESP; reset aborts it
  always_ff @(posedge clk) begin
    if (reset && r_state == S_RESP && !r_err && r_is_wr) begin
      r_ram[w_ram_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: RAM/ROM access, latency, errors,
// held strobes and reset during a wait.
`timescale 1ns/1ps
module tb_mem_bus_responder;

  logic        clk;
  logic        reset;
  logic [12:0] addr;
  logic        rd;
  logic        wr;
  logic        rom_sel;
  logic        ram_sel;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        ready;
  logic        bus_err;
  logic [12:0] rom_addr;
  logic [7:0]  rom_data;

  int errors = 0;
  int checks = 0;

  mem_bus_responder dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .rd       (rd),
    .wr       (wr),
    .rom_sel  (rom_sel),
    .ram_sel  (ram_sel),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready),
    .bus_err  (bus_err),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  // External ROM model
  assign rom_data = rom_addr[7:0] ^ 8'h5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one access, scramble inputs after accept, wait (bounded) for ready,
  // then drop strobes and let the responder return to IDLE. lat=-1 on timeout.
  task automatic do_access(input logic op_rd, input logic op_wr, input logic [12:0] a,
                           input logic rs, input logic ms, input logic [7:0] d,
                           output int lat, output logic e, output logic [7:0] q);
    rd = op_rd; wr = op_wr; addr = a; rom_sel = rs; ram_sel = ms; data_in = d;
    lat = -1; e = 1'b0; q = 8'h00;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        addr = 13'h0555; data_in = ~d; rom_sel = ~rs; ram_sel = ~ms;
      end
      if (ready) begin
        lat = k; e = bus_err; q = data_out;
        break;
      end
    end
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; rom_sel = 1'b0; ram_sel = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    checks++; if (rom_addr !== 13'h0000) begin errors++; $display("FAIL reset_rom_addr: got %h want 0000", rom_addr); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ram_write();
    int lat; logic e; logic [7:0] q;
    do_access(1'b0, 1'b1, 13'h1800, 1'b0, 1'b1, 8'hA5, lat, e, q);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ram_wr_lat: got %0d want 1", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL ram_wr_err: got %b want 0", e); end
    do_access(1'b0, 1'b1, 13'h1C00, 1'b0, 1'b1, 8'h3C, lat, e, q);
    do_access(1'b0, 1'b1, 13'h1FFF, 1'b0, 1'b1, 8'hC3, lat, e, q);
    do_access(1'b1, 1'b0, 13'h1800, 1'b0, 1'b1, 8'h00, lat, e, q);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ram_rd_lat: got %0d want 1", lat); end
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL ram_rd_data: got %h want a5", q); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL ram_rd_err: got %b want 0", e); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ram_rd_pulse_width: got %b want 0", ready); end
  endtask

  task automatic test_rom_read();
    int lat; logic e; logic [7:0] q;
    do_access(1'b1, 1'b0, 13'h0123, 1'b1, 1'b0, 8'h00, lat, e, q);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rom_rd_lat: got %0d want 3", lat); end
    checks++; if (q !== 8'h79) begin errors++; $display("FAIL rom_rd_data: got %h want 79", q); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rom_rd_err: got %b want 0", e); end
    checks++; if (rom_addr !== 13'h0123) begin errors++; $display("FAIL rom_addr: got %h want 0123", rom_addr); end
  endtask

  task automatic test_rom_write_err();
    int lat; logic e; logic [7:0] q;
    do_access(1'b0, 1'b1, 13'h0400, 1'b1, 1'b0, 8'hEE, lat, e, q);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rom_wr_lat: got %0d want 1", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL rom_wr_err: got %b want 1", e); end
    checks++; if (q !== 8'h79) begin errors++; $display("FAIL rom_wr_data_held: got %h want 79", q); end
    do_access(1'b1, 1'b0, 13'h1C00, 1'b0, 1'b1, 8'h00, lat, e, q);
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL rom_wr_ram_intact: got %h want 3c", q); end
  endtask

  task automatic test_bad_request();
    int lat; logic e; logic [7:0] q;
    do_access(1'b1, 1'b1, 13'h1C00, 1'b0, 1'b1, 8'h00, lat, e, q);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rdwr_lat: got %0d want 1", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL rdwr_err: got %b want 1", e); end
    do_access(1'b0, 1'b1, 13'h1C00, 1'b0, 1'b0, 8'hFF, lat, e, q);
    checks++; if (lat !== 1) begin errors++; $display("FAIL nosel_lat: got %0d want 1", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL nosel_err: got %b want 1", e); end
    do_access(1'b0, 1'b1, 13'h1C00, 1'b1, 1'b1, 8'h11, lat, e, q);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL bothsel_err: got %b want 1", e); end
    do_access(1'b1, 1'b0, 13'h1C00, 1'b0, 1'b1, 8'h00, lat, e, q);
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL bad_req_ram_intact: got %h want 3c", q); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL bad_req_recover_err: got %b want 0", e); end
  endtask

  task automatic test_hold_strobe();
    int lat; logic e; logic [7:0] q;
    int pulses;
    pulses = 0;
    rd = 1'b1; wr = 1'b0; addr = 13'h1800; rom_sel = 1'b0; ram_sel = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL hold_data: got %h want a5", data_out); end
    rd = 1'b0;
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 13'h1C00, 1'b0, 1'b1, 8'h00, lat, e, q);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rehold_lat: got %0d want 1", lat); end
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL rehold_data: got %h want 3c", q); end
  endtask

  task automatic test_reset_in_wait();
    int lat; logic e; logic [7:0] q;
    int pulses;
    pulses = 0;
    rd = 1'b1; wr = 1'b0; addr = 13'h0123; rom_sel = 1'b1; ram_sel = 1'b0;
    @(posedge clk); #1;
    rd = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    if (ready) pulses++;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_wait_data: got %h want 00", data_out); end
    checks++; if (rom_addr !== 13'h0000) begin errors++; $display("FAIL rst_wait_rom_addr: got %h want 0000", rom_addr); end
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_wait_pulses: got %0d want 0", pulses); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_wait_data_after: got %h want 00", data_out); end
    do_access(1'b1, 1'b0, 13'h1FFF, 1'b0, 1'b1, 8'h00, lat, e, q);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rst_next_lat: got %0d want 1", lat); end
    checks++; if (q !== 8'hC3) begin errors++; $display("FAIL rst_next_data: got %h want c3", q); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rst_next_err: got %b want 0", e); end
  endtask

  initial begin
    test_reset();
    test_ram_write();
    test_rom_read();
    test_rom_write_err();
    test_bad_request();
    test_hold_strobe();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
